// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, the coefficient type, the control FSM
// state type and the NTT twiddle ROM (Montgomery form, signed 16-bit).
// No ports; imported by every datapath file of the polyvec inner product.
package kyber_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_N    = 256;
  localparam int KYBER_QINV = -3327;  // q^-1 mod 2^16, signed
  localparam int BARRETT_V  = 20159;  // round(2^26 / q)

  typedef logic signed [15:0] coef_t;

  localparam coef_t Q_COEF = 16'sd3329;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam coef_t ZETAS [128] = '{
    -16'sd1044, -16'sd758,  -16'sd359,  -16'sd1517,  16'sd1493,  16'sd1422,  16'sd287,   16'sd202,
    -16'sd171,   16'sd622,   16'sd1577,  16'sd182,   16'sd962,  -16'sd1202, -16'sd1474,  16'sd1468,
     16'sd573,  -16'sd1325,  16'sd264,   16'sd383,  -16'sd829,   16'sd1458, -16'sd1602, -16'sd130,
    -16'sd681,   16'sd1017,  16'sd732,   16'sd608,  -16'sd1542,  16'sd411,  -16'sd205,  -16'sd1571,
     16'sd1223,  16'sd652,  -16'sd552,   16'sd1015, -16'sd1293,  16'sd1491, -16'sd282,  -16'sd1544,
     16'sd516,  -16'sd8,    -16'sd320,  -16'sd666,  -16'sd1618, -16'sd1162,  16'sd126,   16'sd1469,
    -16'sd853,  -16'sd90,   -16'sd271,   16'sd830,   16'sd107,  -16'sd1421, -16'sd247,  -16'sd951,
    -16'sd398,   16'sd961,  -16'sd1508, -16'sd725,   16'sd448,  -16'sd1065,  16'sd677,  -16'sd1275,
    -16'sd1103,  16'sd430,   16'sd555,   16'sd843,  -16'sd1251,  16'sd871,   16'sd1550,  16'sd105,
     16'sd422,   16'sd587,   16'sd177,  -16'sd235,  -16'sd291,  -16'sd460,   16'sd1574,  16'sd1653,
    -16'sd246,   16'sd778,   16'sd1159, -16'sd147,  -16'sd777,   16'sd1483, -16'sd602,   16'sd1119,
    -16'sd1590,  16'sd644,  -16'sd872,   16'sd349,   16'sd418,   16'sd329,  -16'sd156,  -16'sd75,
     16'sd817,   16'sd1097,  16'sd603,   16'sd610,   16'sd1322, -16'sd1285, -16'sd1465,  16'sd384,
    -16'sd1215, -16'sd136,   16'sd1218, -16'sd1335, -16'sd874,   16'sd220,  -16'sd1187, -16'sd1659,
    -16'sd1185, -16'sd1530, -16'sd1278,  16'sd794,  -16'sd1510, -16'sd854,  -16'sd870,   16'sd478,
    -16'sd108,  -16'sd308,   16'sd996,   16'sd991,   16'sd958,  -16'sd1460,  16'sd1522,  16'sd1628
  };

endpackage

// File: rtl/barrett_reduce.sv
// barrett_reduce: combinational Barrett reduction of a signed accumulator
// to the canonical range 0..q-1.
// Ports: x (signed ACC_W-bit accumulator), r (16-bit canonical residue).
module barrett_reduce
  import kyber_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic signed [ACC_W-1:0] x,
  output logic        [15:0]      r
);

  localparam logic signed [39:0] V40 = 40'(BARRETT_V);
  localparam logic signed [39:0] Q40 = 40'(KYBER_Q);
  localparam logic signed [39:0] RND = 40'sd33554432;  // 2^25

  logic signed [39:0] xe;
  logic signed [39:0] t;
  logic signed [39:0] rem;

  always_comb begin
    xe  = 40'(x);
    t   = (xe * V40 + RND) >>> 26;
    rem = xe - t * Q40;
    // Barrett leaves a centred residue; fold it into 0..q-1.
    if (rem < 0) begin
      rem = rem + Q40;
    end else if (rem >= Q40) begin
      rem = rem - Q40;
    end
    r = 16'(rem);
  end

endmodule

// File: rtl/basemul.sv
// basemul: product of two degree-1 polynomials modulo (X^2 - zeta).
// Ports: a0/a1, b0/b1 (signed coefficient pairs), zeta (twiddle),
// r0/r1 (signed result pair, each |r| < 2q).
module basemul
  import kyber_pkg::*;
(
  input  coef_t a0,
  input  coef_t a1,
  input  coef_t b0,
  input  coef_t b1,
  input  coef_t zeta,
  output coef_t r0,
  output coef_t r1
);

  coef_t a1b1;
  coef_t a1b1z;
  coef_t a0b0;
  coef_t a0b1;
  coef_t a1b0;

  fqmul u_a1b1  (.a(a1),   .b(b1),   .r(a1b1));
  fqmul u_a1b1z (.a(a1b1), .b(zeta), .r(a1b1z));
  fqmul u_a0b0  (.a(a0),   .b(b0),   .r(a0b0));
  fqmul u_a0b1  (.a(a0),   .b(b1),   .r(a0b1));
  fqmul u_a1b0  (.a(a1),   .b(b0),   .r(a1b0));

  assign r0 = a1b1z + a0b0;
  assign r1 = a0b1 + a1b0;

endmodule

// File: rtl/fqmul.sv
// fqmul: combinational Montgomery multiply, r = a*b*2^-16 mod q.
// Ports: a, b (signed coefficients), r (signed result, |r| < q for
// |a*b| < 2^15*q).
module fqmul
  import kyber_pkg::*;
(
  input  coef_t a,
  input  coef_t b,
  output coef_t r
);

  localparam logic signed [31:0] QINV32 = KYBER_QINV;
  localparam logic signed [31:0] Q32    = KYBER_Q;

  logic signed [31:0] prod;
  logic signed [31:0] tq_full;
  logic signed [15:0] t;
  logic signed [31:0] diff;

  always_comb begin
    prod    = 32'(a) * 32'(b);
    tq_full = prod * QINV32;
    t       = 16'(tq_full);
    // Low 16 bits of diff are zero by construction, so the shift is exact.
    diff    = prod - 32'(t) * Q32;
    r       = 16'(diff >>> 16);
  end

endmodule

// File: rtl/polyvec_basemul_acc.sv
// polyvec_basemul_acc: streaming NTT-domain inner product r = sum_k a_k o b_k.
// Terms arrive pair-major, poly-minor (K terms per pair back-to-back); the
// 128 reduced pairs leave in index order with a valid/ready handshake.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start / busy / done     job control (start ignored while busy)
//   in_valid / in_ready     input term handshake, in_a0/a1, in_b0/b1 data
//   out_valid / out_ready   output handshake, out_r0/r1 (0..q-1), out_idx
module polyvec_basemul_acc
  import kyber_pkg::*;
#(
  parameter int K     = 3,
  parameter int ACC_W = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_a0,
  input  logic signed [15:0] in_a1,
  input  logic signed [15:0] in_b0,
  input  logic signed [15:0] in_b1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [15:0] out_r0,
  output logic        [15:0] out_r1,
  output logic        [6:0]  out_idx
);

  localparam logic [1:0] K_LAST    = 2'(K - 1);
  localparam logic [6:0] PAIR_LAST = 7'd127;

  function automatic logic signed [ACC_W-1:0] sext(input coef_t v);
    return ACC_W'(v);
  endfunction

  state_t     state_q, state_d;
  logic [1:0] k_cnt_q, k_cnt_d;
  logic [6:0] pair_cnt_q, pair_cnt_d;
  logic       all_taken_q, all_taken_d;
  logic       done_q, done_d;

  logic       en;
  logic       in_hs;
  logic       final_hs;
  coef_t      zeta_rom;
  coef_t      zeta_sel;

  logic       vld_p1_q, vld_p1_d;
  logic       first_p1_q, first_p1_d;
  logic       last_p1_q, last_p1_d;
  logic [6:0] idx_p1_q, idx_p1_d;
  coef_t      a0_p1_q, a0_p1_d, a1_p1_q, a1_p1_d;
  coef_t      b0_p1_q, b0_p1_d, b1_p1_q, b1_p1_d;
  coef_t      zeta_p1_q, zeta_p1_d;
  coef_t      prod0, prod1;

  logic                    vld_p2_q, vld_p2_d;
  logic [6:0]              idx_p2_q, idx_p2_d;
  logic signed [ACC_W-1:0] acc0_p2_q, acc0_p2_d;
  logic signed [ACC_W-1:0] acc1_p2_q, acc1_p2_d;
  logic [15:0]             red0, red1;

  logic        out_valid_q, out_valid_d;
  logic [15:0] out_r0_q, out_r0_d;
  logic [15:0] out_r1_q, out_r1_d;
  logic [6:0]  out_idx_q, out_idx_d;

  // The whole pipeline advances together; only a blocked output freezes it.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = (state_q == ST_RUN) && en && !all_taken_q;
  assign in_hs    = in_valid && in_ready;
  assign final_hs = (state_q == ST_RUN) && out_valid_q && out_ready
                    && (out_idx_q == PAIR_LAST);

  // Odd pairs use the negated twiddle, expressed as q - zeta to stay positive.
  assign zeta_rom = ZETAS[{1'b1, pair_cnt_q[6:1]}];
  assign zeta_sel = pair_cnt_q[0] ? (Q_COEF - zeta_rom) : zeta_rom;

  always_comb begin
    state_d     = state_q;
    k_cnt_d     = k_cnt_q;
    pair_cnt_d  = pair_cnt_q;
    all_taken_d = all_taken_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          k_cnt_d     = 2'd0;
          pair_cnt_d  = 7'd0;
          all_taken_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (in_hs) begin
          if (k_cnt_q == K_LAST) begin
            k_cnt_d    = 2'd0;
            pair_cnt_d = pair_cnt_q + 7'd1;
            if (pair_cnt_q == PAIR_LAST) begin
              all_taken_d = 1'b1;
            end
          end else begin
            k_cnt_d = k_cnt_q + 2'd1;
          end
        end
        if (final_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- S1: capture accepted term, twiddle and position flags ----
  always_comb begin
    vld_p1_d   = en ? in_hs : vld_p1_q;
    a0_p1_d    = in_hs ? in_a0 : a0_p1_q;
    a1_p1_d    = in_hs ? in_a1 : a1_p1_q;
    b0_p1_d    = in_hs ? in_b0 : b0_p1_q;
    b1_p1_d    = in_hs ? in_b1 : b1_p1_q;
    zeta_p1_d  = in_hs ? zeta_sel : zeta_p1_q;
    first_p1_d = in_hs ? (k_cnt_q == 2'd0) : first_p1_q;
    last_p1_d  = in_hs ? (k_cnt_q == K_LAST) : last_p1_q;
    idx_p1_d   = in_hs ? pair_cnt_q : idx_p1_q;
  end

  // ---- S2: basemul and per-coefficient accumulation ----
  basemul u_basemul (
    .a0  (a0_p1_q),
    .a1  (a1_p1_q),
    .b0  (b0_p1_q),
    .b1  (b1_p1_q),
    .zeta(zeta_p1_q),
    .r0  (prod0),
    .r1  (prod1)
  );

  always_comb begin
    vld_p2_d  = vld_p2_q;
    idx_p2_d  = idx_p2_q;
    acc0_p2_d = acc0_p2_q;
    acc1_p2_d = acc1_p2_q;
    if (en) begin
      // vld_p2 marks a completed pair sum, not every accumulated term.
      vld_p2_d = vld_p1_q && last_p1_q;
      if (vld_p1_q) begin
        acc0_p2_d = first_p1_q ? sext(prod0) : acc0_p2_q + sext(prod0);
        acc1_p2_d = first_p1_q ? sext(prod1) : acc1_p2_q + sext(prod1);
        idx_p2_d  = idx_p1_q;
      end
    end
  end

  // ---- S3: reduce the finished pair into the output register ----
  barrett_reduce #(.ACC_W(ACC_W)) u_red0 (.x(acc0_p2_q), .r(red0));
  barrett_reduce #(.ACC_W(ACC_W)) u_red1 (.x(acc1_p2_q), .r(red1));

  always_comb begin
    out_valid_d = out_valid_q;
    out_r0_d    = out_r0_q;
    out_r1_d    = out_r1_q;
    out_idx_d   = out_idx_q;
    if (en) begin
      out_valid_d = vld_p2_q;
      if (vld_p2_q) begin
        out_r0_d  = red0;
        out_r1_d  = red1;
        out_idx_d = idx_p2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_cnt_q     <= 2'd0;
      pair_cnt_q  <= 7'd0;
      all_taken_q <= 1'b0;
      done_q      <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_r0_q    <= 16'd0;
      out_r1_q    <= 16'd0;
      out_idx_q   <= 7'd0;
    end else begin
      state_q     <= state_d;
      k_cnt_q     <= k_cnt_d;
      pair_cnt_q  <= pair_cnt_d;
      all_taken_q <= all_taken_d;
      done_q      <= done_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      out_r0_q    <= out_r0_d;
      out_r1_q    <= out_r1_d;
      out_idx_q   <= out_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    a0_p1_q    <= a0_p1_d;
    a1_p1_q    <= a1_p1_d;
    b0_p1_q    <= b0_p1_d;
    b1_p1_q    <= b1_p1_d;
    zeta_p1_q  <= zeta_p1_d;
    first_p1_q <= first_p1_d;
    last_p1_q  <= last_p1_d;
    idx_p1_q   <= idx_p1_d;
    idx_p2_q   <= idx_p2_d;
    acc0_p2_q  <= acc0_p2_d;
    acc1_p2_q  <= acc1_p2_d;
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_r0    = out_r0_q;
  assign out_r1    = out_r1_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_polyvec_basemul_acc.sv
// Testbench for polyvec_basemul_acc: directed and randomised term streams,
// expected pairs from hand-computed constants or a reference model of the
// C polyvec_basemul_acc_montgomery + poly_reduce.
module tb_polyvec_basemul_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start4 = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] in_a0 = '0, in_a1 = '0, in_b0 = '0, in_b1 = '0;

  logic busy, done, in_ready, out_valid;
  logic [15:0] out_r0, out_r1;
  logic [6:0]  out_idx;
  logic busy4, done4, in_ready4, out_valid4;
  logic [15:0] out_r04, out_r14;
  logic [6:0]  out_idx4;

  bit sel4 = 1'b0;
  logic s_ready, s_ov, s_busy, s_done;
  logic [15:0] s_r0, s_r1;
  logic [6:0]  s_idx;

  int n_checks = 0;
  int n_fail = 0;
  int ta0[512], ta1[512], tb0[512], tb1[512];
  int exp_r0[128], exp_r1[128];

  int ZT[128] = '{
    -1044, -758, -359, -1517, 1493, 1422, 287, 202,
    -171, 622, 1577, 182, 962, -1202, -1474, 1468,
    573, -1325, 264, 383, -829, 1458, -1602, -130,
    -681, 1017, 732, 608, -1542, 411, -205, -1571,
    1223, 652, -552, 1015, -1293, 1491, -282, -1544,
    516, -8, -320, -666, -1618, -1162, 126, 1469,
    -853, -90, -271, 830, 107, -1421, -247, -951,
    -398, 961, -1508, -725, 448, -1065, 677, -1275,
    -1103, 430, 555, 843, -1251, 871, 1550, 105,
    422, 587, 177, -235, -291, -460, 1574, 1653,
    -246, 778, 1159, -147, -777, 1483, -602, 1119,
    -1590, 644, -872, 349, 418, 329, -156, -75,
    817, 1097, 603, 610, 1322, -1285, -1465, 384,
    -1215, -136, 1218, -1335, -874, 220, -1187, -1659,
    -1185, -1530, -1278, 794, -1510, -854, -870, 478,
    -108, -308, 996, 991, 958, -1460, 1522, 1628
  };

  always #5 clk = ~clk;

  polyvec_basemul_acc #(.K(3), .ACC_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r0(out_r0), .out_r1(out_r1), .out_idx(out_idx)
  );

  polyvec_basemul_acc #(.K(4), .ACC_W(18)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_r0(out_r04), .out_r1(out_r14), .out_idx(out_idx4)
  );

  assign s_ready = sel4 ? in_ready4  : in_ready;
  assign s_ov    = sel4 ? out_valid4 : out_valid;
  assign s_busy  = sel4 ? busy4      : busy;
  assign s_done  = sel4 ? done4      : done;
  assign s_r0    = sel4 ? out_r04    : out_r0;
  assign s_r1    = sel4 ? out_r14    : out_r1;
  assign s_idx   = sel4 ? out_idx4   : out_idx;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mont(input int a);
    int t;
    t = int'(shortint'(a * -3327));
    return (a - t * 3329) >>> 16;
  endfunction

  function automatic int fq(input int a, input int b);
    return mont(a * b);
  endfunction

  function automatic int canon(input int s);
    return ((s % 3329) + 3329) % 3329;
  endfunction

  function automatic void build_expected(input int kk);
    int s0, s1, z, i;
    for (int j = 0; j < 128; j++) begin
      s0 = 0;
      s1 = 0;
      z = ZT[64 + j / 2];
      if (j % 2 == 1) z = -z;
      for (int k = 0; k < kk; k++) begin
        i = j * kk + k;
        s0 += fq(fq(ta1[i], tb1[i]), z) + fq(ta0[i], tb0[i]);
        s1 += fq(ta0[i], tb1[i]) + fq(ta1[i], tb0[i]);
      end
      exp_r0[j] = canon(s0);
      exp_r1[j] = canon(s1);
    end
  endfunction

  function automatic void clear_all();
    for (int i = 0; i < 512; i++) begin
      ta0[i] = 0; ta1[i] = 0; tb0[i] = 0; tb1[i] = 0;
    end
    for (int j = 0; j < 128; j++) begin
      exp_r0[j] = 0; exp_r1[j] = 0;
    end
  endfunction

  function automatic int rnd_coef();
    return int'($urandom_range(0, 6656)) - 3328;
  endfunction

  function automatic int ext_coef();
    return ($urandom_range(0, 1) == 1) ? 3328 : -3328;
  endfunction

  function automatic void fill_random(input int kk);
    for (int i = 0; i < 128 * kk; i++) begin
      ta0[i] = rnd_coef(); ta1[i] = rnd_coef();
      tb0[i] = rnd_coef(); tb1[i] = rnd_coef();
    end
  endfunction

  function automatic void fill_extreme(input int kk);
    for (int i = 0; i < 128 * kk; i++) begin
      ta0[i] = ext_coef(); ta1[i] = ext_coef();
      tb0[i] = ext_coef(); tb1[i] = ext_coef();
    end
  endfunction

  task automatic drive(input int sent, input int nterms, input int gap, input int stall);
    if (sent < nterms && int'($urandom_range(0, 99)) >= gap) begin
      in_valid = 1'b1;
      in_a0 = 16'(ta0[sent]);
      in_a1 = 16'(ta1[sent]);
      in_b0 = 16'(tb0[sent]);
      in_b1 = 16'(tb1[sent]);
    end else begin
      in_valid = 1'b0;
    end
    out_ready = (int'($urandom_range(0, 99)) >= stall);
  endtask

  task automatic check_all_zero(input string tg);
    check_val({tg, " out_valid"}, int'(s_ov), 0);
    check_val({tg, " out_r0"}, int'(s_r0), 0);
    check_val({tg, " out_r1"}, int'(s_r1), 0);
    check_val({tg, " out_idx"}, int'(s_idx), 0);
    check_val({tg, " busy"}, int'(s_busy), 0);
    check_val({tg, " done"}, int'(s_done), 0);
    check_val({tg, " in_ready"}, int'(s_ready), 0);
  endtask

  task automatic run_job(input bit use4, input int kk, input int gap, input int stall,
                         input int abort_at, input bit mid_start, input string tg);
    int nterms, sent, got, cyc, hs_last0;
    bit fin, held, mid_done;
    logic [15:0] h_r0, h_r1;
    logic [6:0]  h_idx;
    nterms = 128 * kk;
    sent = 0; got = 0; cyc = 0; hs_last0 = -1;
    fin = 1'b0; held = 1'b0; mid_done = 1'b0;
    h_r0 = '0; h_r1 = '0; h_idx = '0;
    sel4 = use4;
    @(posedge clk); #1;
    if (use4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start4 = 1'b0;
    check_val({tg, " busy_on_start"}, int'(s_busy), 1);
    drive(sent, nterms, gap, stall);
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        check_val($sformatf("%s stall_r0[%0d]", tg, got), int'(s_r0), int'(h_r0));
        check_val($sformatf("%s stall_r1[%0d]", tg, got), int'(s_r1), int'(h_r1));
        check_val($sformatf("%s stall_idx[%0d]", tg, got), int'(s_idx), int'(h_idx));
      end
      if (s_ov && !out_ready)
        check_val($sformatf("%s stall_in_ready[%0d]", tg, got), int'(s_ready), 0);
      held = s_ov && !out_ready;
      h_r0 = s_r0; h_r1 = s_r1; h_idx = s_idx;
      if (in_valid && s_ready) begin
        if (sent == kk - 1) hs_last0 = cyc;
        sent++;
      end
      if (s_ov && out_ready) begin
        if (got == 0 && gap == 0 && stall == 0)
          check_val({tg, " latency"}, cyc - hs_last0, 3);
        check_val($sformatf("%s idx[%0d]", tg, got), int'(s_idx), got);
        check_val($sformatf("%s r0[%0d]", tg, got), int'(s_r0), exp_r0[got]);
        check_val($sformatf("%s r1[%0d]", tg, got), int'(s_r1), exp_r1[got]);
        got++;
        if (got == 128) begin
          check_val({tg, " done_early"}, int'(s_done), 0);
          @(negedge clk);
          check_val({tg, " done_pulse"}, int'(s_done), 1);
          check_val({tg, " busy_end"}, int'(s_busy), 0);
          @(negedge clk);
          check_val({tg, " done_clear"}, int'(s_done), 0);
          fin = 1'b1;
        end
      end
      if (!fin && abort_at >= 0 && sent == abort_at) begin
        @(posedge clk); #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero({tg, " abort"});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val({tg, " no_done_after_abort"}, int'(s_done), 0);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        if (mid_start && got >= 5 && !mid_done) begin
          start = 1'b1;
          mid_done = 1'b1;
        end else begin
          start = 1'b0;
        end
        drive(sent, nterms, gap, stall);
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (!fin) check_val({tg, " timeout"}, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Pair 0: a0=b0=1 in every term -> 3*169. Pair 1 (odd): a1=b1=1 in k=0
    // -> negated twiddle gives 456. Pair 3: a0=b1=1 in k=1 -> r1=169.
    clear_all();
    for (int k = 0; k < 3; k++) begin
      ta0[k] = 1; tb0[k] = 1;
    end
    ta1[3] = 1; tb1[3] = 1;
    ta0[10] = 1; tb1[10] = 1;
    exp_r0[0] = 507;
    exp_r0[1] = 456;
    exp_r1[3] = 169;
    run_job(1'b0, 3, 0, 0, -1, 1'b0, "t1");

    // Pair 0 with a1=b1=1 in k=0: fqmul(169, -1103) = -456 -> 2873.
    clear_all();
    ta1[0] = 1; tb1[0] = 1;
    exp_r0[0] = 2873;
    run_job(1'b0, 3, 0, 0, -1, 1'b0, "t2");

    fill_random(3);
    build_expected(3);
    run_job(1'b0, 3, 0, 0, -1, 1'b0, "t3");
    run_job(1'b0, 3, 50, 50, -1, 1'b0, "t4");

    fill_extreme(4);
    build_expected(4);
    run_job(1'b1, 4, 20, 30, -1, 1'b0, "t5");

    fill_random(3);
    build_expected(3);
    run_job(1'b0, 3, 0, 0, 40 * 3 + 2, 1'b0, "t6a");
    run_job(1'b0, 3, 10, 20, -1, 1'b1, "t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
